// File: rtl/stream_demux_n.sv
// Registered 1-to-NUM_OUT stream demultiplexer with valid/ready on every port.
// Routes by sel, broadcasts to all lanes, or round-robins over an internal pointer.
module stream_demux_n #(
    parameter int DATA_WIDTH = 12,
    parameter int NUM_OUT    = 16,
    localparam int SEL_WIDTH = $clog2(NUM_OUT)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic [1:0]                    mode,
    input  logic [SEL_WIDTH-1:0]          sel,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [NUM_OUT*DATA_WIDTH-1:0] out_data,
    output logic [NUM_OUT-1:0]            out_valid,
    input  logic [NUM_OUT-1:0]            out_ready,
    output logic [SEL_WIDTH-1:0]          rr_ptr,
    output logic                          err_drop
);

    localparam logic [1:0] MODE_ADDR  = 2'b00;
    localparam logic [1:0] MODE_BCAST = 2'b01;
    localparam logic [1:0] MODE_RR    = 2'b10;

    logic [DATA_WIDTH-1:0] lane_data_p1 [NUM_OUT];
    logic [NUM_OUT-1:0]    lane_vld_p1;
    logic [SEL_WIDTH-1:0]  rr_ptr_p1;
    logic                  err_drop_p1;

    logic [NUM_OUT-1:0] lane_free;
    logic [NUM_OUT-1:0] lane_wr;
    logic               sel_oor;
    logic               free_at_sel;
    logic               free_at_rr;
    logic               in_ready_c;
    logic               accept;

    // A lane can take a new word if it is empty or being drained this cycle.
    assign lane_free = ~lane_vld_p1 | out_ready;
    assign sel_oor   = ({1'b0, sel} >= (SEL_WIDTH + 1)'(NUM_OUT));

    always_comb begin
        free_at_sel = 1'b0;
        free_at_rr  = 1'b0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (sel == SEL_WIDTH'(i))
                free_at_sel = lane_free[i];
            if (rr_ptr_p1 == SEL_WIDTH'(i))
                free_at_rr = lane_free[i];
        end
    end

    always_comb begin
        in_ready_c = 1'b0;
        if (!clear) begin
            case (mode)
                MODE_ADDR:  in_ready_c = sel_oor | free_at_sel;
                MODE_BCAST: in_ready_c = &lane_free;
                MODE_RR:    in_ready_c = free_at_rr;
                default:    in_ready_c = 1'b0;
            endcase
        end
    end

    assign accept = in_valid & in_ready_c;

    always_comb begin
        lane_wr = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            lane_wr[i] = accept &&
                         ((mode == MODE_ADDR && !sel_oor && sel == SEL_WIDTH'(i)) ||
                          (mode == MODE_BCAST) ||
                          (mode == MODE_RR && rr_ptr_p1 == SEL_WIDTH'(i)));
        end
    end

    // Stage p1: per-lane holding registers; an empty lane always shows zero data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_vld_p1 <= '0;
            for (int i = 0; i < NUM_OUT; i++)
                lane_data_p1[i] <= '0;
        end else if (clear) begin
            lane_vld_p1 <= '0;
            for (int i = 0; i < NUM_OUT; i++)
                lane_data_p1[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (lane_wr[i]) begin
                    lane_data_p1[i] <= in_data;
                    lane_vld_p1[i]  <= 1'b1;
                end else if (lane_vld_p1[i] && out_ready[i]) begin
                    lane_data_p1[i] <= '0;
                    lane_vld_p1[i]  <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_p1 <= '0;
        end else if (clear) begin
            rr_ptr_p1 <= '0;
        end else if (accept && mode == MODE_RR) begin
            if (rr_ptr_p1 == SEL_WIDTH'(NUM_OUT - 1))
                rr_ptr_p1 <= '0;
            else
                rr_ptr_p1 <= rr_ptr_p1 + 1'b1;
        end
    end

    // clear forces in_ready low, so no drop can be flagged on the cycle after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_drop_p1 <= 1'b0;
        else
            err_drop_p1 <= accept && (mode == MODE_ADDR) && sel_oor;
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_lane
        assign out_data[g*DATA_WIDTH +: DATA_WIDTH] = lane_data_p1[g];
    end

    assign out_valid = lane_vld_p1;
    assign in_ready  = in_ready_c;
    assign rr_ptr    = rr_ptr_p1;
    assign err_drop  = err_drop_p1;

endmodule

// File: doc/stream_demux_n.md
Name: stream_demux_n

Overview:
- Registered, flow-controlled 1-to-NUM_OUT demultiplexer with valid/ready handshakes on the input and on every output.
- Distributes activation or weight words from one producer to NUM_OUT processing-element lanes of the NPU array.
- Three routing modes: addressed (by sel), broadcast (all lanes), and round-robin (internal pointer).
- Each output lane has a one-entry holding register, so a stalled lane never corrupts another lane's data.

Parameters:
- DATA_WIDTH, 12, width of each data word.
- NUM_OUT, 16, number of output lanes, 2..64.
- SEL_WIDTH, $clog2(NUM_OUT), width of sel and rr_ptr. This is a localparam and cannot be overridden.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush: invalidates all lanes and zeroes rr_ptr.
- mode  in  2  routing mode: 00 addressed, 01 broadcast, 10 round-robin, 11 reserved.
- sel  in  SEL_WIDTH  target lane in addressed mode.
- in_data  in  DATA_WIDTH  input word.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept in_data this cycle.
- out_data  out  NUM_OUT*DATA_WIDTH  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  NUM_OUT  per-lane valid.
- out_ready  in  NUM_OUT  per-lane consumer ready.
- rr_ptr  out  SEL_WIDTH  next round-robin target lane.
- err_drop  out  1  one-cycle pulse when an accepted word is discarded.

Behaviour:
- Reset (rst_n low, asynchronous): all out_valid=0, all out_data=0, rr_ptr=0, err_drop=0.
- in_ready is combinational from the current state plus mode/sel/out_ready/clear.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer on lane i occurs when out_valid[i] && out_ready[i].
- Lane i is "free" when out_valid[i]=0, or when out_valid[i]=1 and out_ready[i]=1 in the same cycle (drain-and-refill, full throughput).
- in_ready by mode:
  - addressed: lane[sel] free. If sel >= NUM_OUT, in_ready=1 (the word is dropped, see below).
  - broadcast: all lanes free.
  - round-robin: lane[rr_ptr] free.
  - reserved (11): in_ready=0.
  - Any mode with clear=1: in_ready=0.
- On an input transfer, in_data is written to the target lane register(s) and the corresponding out_valid is set. It appears on out_data/out_valid the next cycle (latency 1).
- Broadcast writes every lane in the same cycle.
- mode and sel are sampled only on the input-transfer cycle. Changing them while a word is stalled affects only the routing of the next word.
- Lane data hold: out_data[i] stays stable while out_valid[i]=1 and out_ready[i]=0.
- Lane zeroing: when a lane drains without a refill, out_valid[i] clears and out_data[i] returns to 0. An invalid lane always presents 0.
- Lanes not targeted by a transfer are unaffected; they keep draining independently.
- Round-robin pointer:
  - rr_ptr advances by 1 only on an input transfer in round-robin mode.
  - It wraps from NUM_OUT-1 to 0.
  - It is held in all other modes and during stalls.
- Out-of-range sel (addressed mode, sel >= NUM_OUT, reachable only when NUM_OUT is not a power of two):
  - The word is accepted and discarded.
  - No lane changes.
  - err_drop=1 for the following cycle only.
- clear=1:
  - Next cycle: all out_valid=0, all out_data=0, rr_ptr=0.
  - clear takes priority over simultaneous output transfers and any pending input (in_ready is forced 0).
  - err_drop is 0 the cycle after clear.
- Reset asserted mid-operation discards all held words immediately. No partial state survives.
- No combinational path exists from in_data to out_data. The only combinational paths are out_ready/mode/sel/clear -> in_ready.

Test Plan:
- Addressed, NUM_OUT=16: send 0xA5A to sel=3, then 0x123 to sel=15, all out_ready=1 -> lane 3 valid with 0xA5A one cycle after acceptance; lane 15 valid with 0x123 one cycle later; all other lanes stay out_valid=0, data=0.
- Backpressure: lane 5 holds 0x0F0 with out_ready[5]=0, then a second word is targeted to sel=5 -> in_ready=0 and lane 5 stays 0x0F0. Raise out_ready[5] -> second word is accepted in that same cycle and appears next cycle, with no bubble.
- Broadcast: lane 7 stalled (out_ready[7]=0), in_data=0x7FF, mode=01 -> in_ready=0 until lane 7 drains; then all 16 lanes show 0x7FF simultaneously.
- Round-robin: 18 consecutive words 1..18, mode=10, all ready -> words land on lanes 0..15 then 0,1; rr_ptr reads 2 at the end. During a 3-cycle lane-0 stall, rr_ptr holds.
- NUM_OUT=12, addressed, sel=13, word 0x555 -> accepted; err_drop high for exactly 1 cycle; no out_valid changes.
- Mid-stream flush and reset: 4 lanes valid, rr_ptr=6, pulse clear -> next cycle all out_valid=0, out_data=0, rr_ptr=0, in_ready=0 during clear. Repeat with rst_n asserted asynchronously between clock edges -> outputs go to 0 immediately.
